psum_acc_buf: RTL
=================

PSUM_ACC_BUF -- requirements
Module: psum_acc_buf

Interface
REQ-001 Parameter PSUM_BW, default 32, partial-sum width from the MAC stage.
REQ-002 Parameter PSUM_ROW_MEM_ADDR, default 12, accumulation buffer address width (depth 2^12 covers IMG_W x OC = 32 x 64 = 2048).
REQ-003 Parameter OUT_BW, default 8, quantized output width.
REQ-004 Port clk  in  1  single clock; all logic on its rising edge.
REQ-005 Port resetn  in  1  asynchronous, active-high reset (asserted = 1).
REQ-006 Port start  in  1  one-cycle pulse that begins a tile; sampled only in IDLE.
REQ-007 Port tile_len  in  PSUM_ROW_MEM_ADDR+1  number of words in the tile, 1..2^PSUM_ROW_MEM_ADDR, latched on start.
REQ-008 Port q_shift  in  5  right-shift amount for quantization, latched on start.
REQ-009 Port relu_en  in  1  clamps negative outputs to 0, latched on start.
REQ-010 Port psum_valid  in  1  psum_data/psum_addr are valid this cycle.
REQ-011 Port psum_data  in  PSUM_BW  signed partial sum from the MAC.
REQ-012 Port psum_addr  in  PSUM_ROW_MEM_ADDR  target word address.
REQ-013 Port acc_last  in  1  pulse: no further partial sums for this tile.
REQ-014 Port psum_ready  out  1  high only in ACCUM.
REQ-015 Port out_data  out  OUT_BW  signed quantized word.
REQ-016 Port out_valid  out  1  out_data valid.
REQ-017 Port out_ready  in  1  downstream accepts out_data.
REQ-018 Port busy  out  1  state != IDLE.
REQ-019 Port done  out  1  one-cycle pulse after the last output word is accepted.

Function
REQ-020 The FSM SHALL have states IDLE, CLEAR, ACCUM, FLUSH and DRAIN.
REQ-021 Transitions SHALL be: IDLE->CLEAR on start; CLEAR->ACCUM after tile_len zero-writes (addresses 0..tile_len-1, one per cycle); ACCUM->FLUSH on acc_last; FLUSH->DRAIN once the accumulate pipeline is empty (2 cycles); DRAIN->IDLE after the final word handshake, with done pulsing in that same IDLE-entry cycle.
REQ-022 A partial sum SHALL be accepted on psum_valid && psum_ready; psum_valid outside ACCUM SHALL be ignored.
REQ-023 Accumulation SHALL be read-modify-write: mem[addr] <= mem[addr] + psum_data, wrapping modulo 2^PSUM_BW (two's complement).
REQ-024 The write SHALL commit 2 cycles after acceptance; one accepted sum per cycle is sustained.
REQ-025 Any address sequence, including back-to-back or alternating repeats of the same address, SHALL give the exact sum; the design forwards the in-flight result rather than stalling.
REQ-026 A psum_addr >= tile_len SHALL be accepted and written, and has no effect on the drained output.
REQ-027 DRAIN SHALL read addresses 0..tile_len-1 in order, with a 1-cycle read latency before the first out_valid.
REQ-028 Quantization SHALL be: r = (acc + (q_shift ? 1<<(q_shift-1) : 0)) >>> q_shift, computed at PSUM_BW+1 bits; then saturated to [-128, 127]; then max(r, 0) if relu_en.
REQ-029 out_data/out_valid SHALL hold stable while out_valid && !out_ready; the read pointer SHALL advance only on a handshake.
REQ-030 acc_last in the same cycle as psum_valid SHALL accept that final sum before FLUSH.
REQ-031 start while busy SHALL be ignored.

Reset
REQ-032 On resetn=1: state=IDLE; psum_ready=0; out_valid=0; out_data=0; busy=0; done=0; pipeline valids cleared; latched config cleared.
REQ-033 Reset mid-tile SHALL abandon the tile; memory contents are undefined, because CLEAR reinitializes on the next start.

Structure
REQ-034 FSM state encodings and the saturation limits (OUT_MAX=127, OUT_MIN=-128) SHALL live in the shared NPU package.
REQ-035 The accumulation memory SHALL be a separate sub-module psum_row_mem: simple dual-port, 1 write and 1 synchronous read port, inferable as block RAM.

Verification
REQ-036 tile_len=4, sums (a0,+5),(a0,+7),(a0,-2) back-to-back, q_shift=0 -> out word0 = 10, words 1..3 = 0, then done.
REQ-037 tile_len=1, 300 x (a0,+1), q_shift=0 -> out = 127 (saturated); same run with -1 and relu_en=0 -> -128.
REQ-038 acc=-6, q_shift=2, relu_en=0 -> -1; acc=6 -> 2; acc=-6 with relu_en=1 -> 0.
REQ-039 tile_len=2048, one +1 per address, out_ready toggling every cycle -> 2048 ones, out_data stable while stalled, exactly one done pulse.
REQ-040 resetn asserted during ACCUM, then start with tile_len=2 and no sums -> outputs 0,0 (CLEAR effective).
REQ-041 Alternating a3,a5,a3,a5 with +1 each, acc_last coincident with the last sum -> words 3 and 5 = 2.

Source files
------------

// File: rtl/psum_acc_buf_pkg.sv
// Shared NPU definitions: tile FSM encoding, output saturation limits and
// the depth of the accumulate read-modify-write pipeline.
package psum_acc_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  // Accept -> read/add/write -> write-back register (forwarding source).
  localparam int ACC_STAGES = 2;

endpackage

// File: rtl/psum_row_mem.sv
// Simple dual-port accumulation RAM: one write port, one registered read
// port with read-first behaviour on a same-address collision.
module psum_row_mem #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Block-RAM style array: no reset, synchronous write and read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/psum_acc_buf.sv
// Partial-sum accumulation buffer: clears a tile, accumulates MAC partial
// sums by read-modify-write with in-flight forwarding, then drains the tile
// through round/shift/saturate/ReLU quantization with a valid/ready output.
module psum_acc_buf
  import psum_acc_buf_pkg::*;
#(
  parameter int PSUM_BW           = 32,
  parameter int PSUM_ROW_MEM_ADDR = 12,
  parameter int OUT_BW            = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [PSUM_ROW_MEM_ADDR:0]   tile_len,
  input  logic [4:0]                   q_shift,
  input  logic                         relu_en,
  input  logic                         psum_valid,
  input  logic signed [PSUM_BW-1:0]    psum_data,
  input  logic [PSUM_ROW_MEM_ADDR-1:0] psum_addr,
  input  logic                         acc_last,
  output logic                         psum_ready,
  output logic signed [OUT_BW-1:0]     out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int AW     = PSUM_ROW_MEM_ADDR;
  localparam int STAGES = ACC_STAGES;

  localparam logic signed [PSUM_BW:0] Q_MAX     = (PSUM_BW+1)'(OUT_MAX);
  localparam logic signed [PSUM_BW:0] Q_MIN     = (PSUM_BW+1)'(OUT_MIN);
  localparam logic [OUT_BW-1:0]       OUT_MAX_W = OUT_BW'(OUT_MAX);
  localparam logic [OUT_BW-1:0]       OUT_MIN_W = OUT_BW'(OUT_MIN);

  state_e state, state_nxt;

  // Latched tile configuration
  logic [AW:0]   len_q, len_m1;
  logic [4:0]    shift_q;
  logic          relu_q;

  logic [AW-1:0] clr_ptr;
  logic [AW-1:0] rd_ptr;

  // Accumulate pipeline: [1] = add/write stage, [2] = write-back register
  logic [STAGES:1]     vld_pipe;
  logic                acc_fire;
  logic [AW-1:0]       s1_addr, wb_addr;
  logic [PSUM_BW-1:0]  s1_data, wb_sum;
  logic                fwd_hit;
  logic [PSUM_BW-1:0]  acc_base, acc_sum;

  // Drain control
  logic          drain_rd;
  logic [AW-1:0] drain_addr;
  logic          hs;
  logic          rd_pend;

  // RAM ports
  logic               mem_we, mem_re;
  logic [AW-1:0]      mem_waddr, mem_raddr;
  logic [PSUM_BW-1:0] mem_wdata, mem_rdata;

  // Quantizer
  logic signed [PSUM_BW:0] q_ext, q_rnd, q_sum, q_shr;
  logic [OUT_BW-1:0]       q_word;

  assign len_m1 = len_q - (AW+1)'(1);

  // State register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-state control strobes
  always_comb begin
    state_nxt  = state;
    acc_fire   = 1'b0;
    drain_rd   = 1'b0;
    drain_addr = '0;
    hs         = 1'b0;
    psum_ready = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: if ({1'b0, clr_ptr} == len_m1) state_nxt = ST_ACCUM;
      ST_ACCUM: begin
        psum_ready = 1'b1;
        acc_fire   = psum_valid;
        if (acc_last) state_nxt = ST_FLUSH;
      end
      // Last write commits once the add stage is empty; the read of word 0
      // issued here therefore sees the final sum.
      ST_FLUSH: if (!vld_pipe[1]) begin
        state_nxt = ST_DRAIN;
        drain_rd  = 1'b1;
      end
      ST_DRAIN: begin
        hs = out_valid && out_ready;
        if (hs) begin
          if ({1'b0, rd_ptr} == len_m1) begin
            state_nxt = ST_IDLE;
          end else begin
            drain_rd   = 1'b1;
            drain_addr = rd_ptr + AW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Tile configuration, clear pointer and drain pointer
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      len_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      clr_ptr <= '0;
      rd_ptr  <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        len_q   <= tile_len;
        shift_q <= q_shift;
        relu_q  <= relu_en;
        clr_ptr <= '0;
      end
      if (state == ST_CLEAR) clr_ptr <= clr_ptr + AW'(1);
      if (drain_rd)          rd_ptr  <= drain_addr;
    end
  end

  // Accumulate pipeline registers and write-back (forwarding) register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      vld_pipe <= '0;
      s1_addr  <= '0;
      s1_data  <= '0;
      wb_addr  <= '0;
      wb_sum   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], acc_fire};
      if (acc_fire) begin
        s1_addr <= psum_addr;
        s1_data <= psum_data;
      end
      if (vld_pipe[1]) begin
        wb_addr <= s1_addr;
        wb_sum  <= acc_sum;
      end
    end
  end

  // The RAM read for a sum was issued one cycle before the previous sum's
  // write landed, so a same-address predecessor is taken from write-back.
  assign fwd_hit  = vld_pipe[2] && (wb_addr == s1_addr);
  assign acc_base = fwd_hit ? wb_sum : mem_rdata;
  assign acc_sum  = acc_base + s1_data;

  // RAM write port: zero-fill during CLEAR, accumulated sum otherwise
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = s1_addr;
    mem_wdata = acc_sum;
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr;
      mem_wdata = '0;
    end else if (vld_pipe[1]) begin
      mem_we    = 1'b1;
    end
  end

  assign mem_re    = acc_fire || drain_rd;
  assign mem_raddr = acc_fire ? psum_addr : drain_addr;

  psum_row_mem #(
    .DW (PSUM_BW),
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Round-half-up shift at one extra bit, saturate, optional ReLU
  always_comb begin
    q_ext = {mem_rdata[PSUM_BW-1], mem_rdata};
    q_rnd = (shift_q == 5'd0) ? '0 : ((PSUM_BW+1)'(1) <<< (shift_q - 5'd1));
    q_sum = q_ext + q_rnd;
    q_shr = q_sum >>> shift_q;
    if (relu_q && q_shr[PSUM_BW]) q_word = '0;
    else if (q_shr > Q_MAX)       q_word = OUT_MAX_W;
    else if (q_shr < Q_MIN)       q_word = OUT_MIN_W;
    else                          q_word = q_shr[OUT_BW-1:0];
  end

  // Output register: loads one cycle after each drain read, holds until
  // accepted; done marks the cycle the FSM re-enters IDLE.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      rd_pend   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      rd_pend <= drain_rd;
      done    <= (state == ST_DRAIN) && (state_nxt == ST_IDLE);
      if (rd_pend) begin
        out_valid <= 1'b1;
        out_data  <= q_word;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
